// File: rtl/seq_divider_16bit_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_divider_16bit_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_16bit_trial_sub.sv
// Trial subtractor for one restoring-division step: a - b as a + ~b + 1.
module div_trial_sub
   import seq_divider_16bit_pkg::*;
#(
   parameter int W = DEF_WIDTH + 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         no_borrow_o
);

   logic [W:0] sum;

   // Carry-out of the inverted-subtrahend add is 1 exactly when a >= b.
   assign sum = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
   assign {no_borrow_o, diff_o} = sum;

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// quotient/remainder/div_by_zero registered and held until the next FIN.
module seq_divider_16bit
   import seq_divider_16bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   // Handshake: start is taken only in IDLE; busy rises on that edge and
   // falls on the edge that raises the one-cycle done pulse.
   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dsr_q;
   logic               dbz_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   quotient_q;
   logic [WIDTH-1:0]   remainder_q;
   logic               div_by_zero_q;

   logic [2*WIDTH:0]   rq_shift;
   logic [WIDTH:0]     trial_diff;
   logic               no_borrow;
   logic [WIDTH:0]     rem_d;
   logic [WIDTH-1:0]   quo_d;

   assign rq_shift = {rem_q, quo_q} << 1;

   div_trial_sub #(
      .W (WIDTH + 1)
   ) u_trial_sub (
      .a_i         (rq_shift[2*WIDTH:WIDTH]),
      .b_i         ({1'b0, dsr_q}),
      .diff_o      (trial_diff),
      .no_borrow_o (no_borrow)
   );

   // Borrow restores the shifted partial remainder; the new quotient bit
   // enters at the bottom of the shifting dividend register.
   assign rem_d = no_borrow ? trial_diff : rq_shift[2*WIDTH:WIDTH];
   assign quo_d = rq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, no_borrow};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dsr_q         <= '0;
         dbz_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  quo_q   <= dividend;
                  dsr_q   <= divisor;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  dbz_q   <= (divisor == '0);
                  busy_q  <= 1'b1;
                  state_q <= (divisor == '0) ? FIN : RUN;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= FIN;
               end
            end
            FIN: begin
               done_q        <= 1'b1;
               busy_q        <= 1'b0;
               div_by_zero_q <= dbz_q;
               // On divide-by-zero the untouched dividend is still in quo_q.
               quotient_q    <= dbz_q ? WIDTH'(DBZ_QUOTIENT) : quo_q;
               remainder_q   <= dbz_q ? quo_q : rem_q[WIDTH-1:0];
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: vector table, corner-case
// sequences and a random regression feeding an expected-result queue.
module tb_seq_divider_16bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic [1:0]  dbg_state;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          accepted = 0;
   logic [32:0] exp_q[$];
   logic [32:0] last_exp = '0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          inj;
   } vec_t;

   vec_t vecs[10];

   seq_divider_16bit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
      if (b == 16'd0) return {1'b1, 16'hFFFF, a};
      return {1'b0, a / b, a % b};
   endfunction

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("quotient", quotient, e[31:16]);
            chk("remainder", remainder, e[15:0]);
            chk("div_by_zero", div_by_zero, e[32]);
         end
      end
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [32:0] exp, input int inject);
      int n;
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk);
      exp_q.push_back(exp);
      accepted++;
      @(negedge clk);
      start = 1'b0;
      dividend = 16'($urandom);
      divisor = 16'($urandom);
      chk("busy_after_accept", busy, 1);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (inject != 0 && n == inject) begin
            start = 1'b1;
            dividend = 16'd50;
            divisor = 16'd5;
         end else begin
            start = 1'b0;
         end
         if (n == 8) chk("outputs_held", {div_by_zero, quotient, remainder}, last_exp);
      end
      chk("latency", n, (b == 16'd0) ? 1 : 17);
      chk("busy_low_with_done", busy, 0);
      last_exp = exp;
   endtask

   initial begin
      vecs[0] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,   r: 16'd2, dbz: 1'b0, inj: 0};
      vecs[1] = '{a: 16'hFFFF,  b: 16'd1,     q: 16'hFFFF, r: 16'd0, dbz: 1'b0, inj: 0};
      vecs[2] = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,    r: 16'd0, dbz: 1'b0, inj: 0};
      vecs[3] = '{a: 16'd3,     b: 16'd10,    q: 16'd0,    r: 16'd3, dbz: 1'b0, inj: 0};
      vecs[4] = '{a: 16'd5,     b: 16'd0,     q: 16'hFFFF, r: 16'd5, dbz: 1'b1, inj: 0};
      vecs[5] = '{a: 16'd9,     b: 16'd3,     q: 16'd3,    r: 16'd0, dbz: 1'b0, inj: 0};
      vecs[6] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,    r: 16'd0, dbz: 1'b0, inj: 0};
      vecs[7] = '{a: 16'd0,     b: 16'd0,     q: 16'hFFFF, r: 16'd0, dbz: 1'b1, inj: 0};
      vecs[8] = '{a: 16'd1000,  b: 16'd3,     q: 16'd333,  r: 16'd1, dbz: 1'b0, inj: 4};
      vecs[9] = '{a: 16'd1234,  b: 16'd1234,  q: 16'd1,    r: 16'd0, dbz: 1'b0, inj: 0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_state", dbg_state, 0);

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].q, vecs[i].r}, vecs[i].inj);
      end

      // Start held high: back-to-back operations, 18 cycles apart.
      begin
         int seen;
         int cyc;
         int last;
         seen = 0;
         cyc = 0;
         last = 0;
         @(negedge clk);
         start = 1'b1;
         dividend = 16'd20;
         divisor = 16'd6;
         for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 16'd3, 16'd2});
            accepted++;
         end
         while (seen < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (seen > 0 && cyc == last + 1) begin
               chk("b2b_done_one_cycle", done, 0);
               chk("b2b_busy_reaccept", busy, 1);
            end
            if (done) begin
               seen++;
               if (seen == 3) start = 1'b0;
               if (seen > 1) chk("b2b_gap", cyc - last, 18);
               last = cyc;
            end
         end
         chk("b2b_count", seen, 3);
         start = 1'b0;
         repeat (2) @(negedge clk);
         chk("b2b_no_extra_accept", busy, 0);
         last_exp = {1'b0, 16'd3, 16'd2};
      end

      // Reset in the middle of an operation discards it without a done.
      begin
         int dcount;
         @(negedge clk);
         start = 1'b1;
         dividend = 16'hABCD;
         divisor = 16'h0012;
         @(negedge clk);
         start = 1'b0;
         repeat (7) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("midrst_busy", busy, 0);
         chk("midrst_done", done, 0);
         chk("midrst_quotient", quotient, 0);
         chk("midrst_remainder", remainder, 0);
         chk("midrst_dbz", div_by_zero, 0);
         chk("midrst_state", dbg_state, 0);
         dcount = 0;
         repeat (25) begin
            @(negedge clk);
            if (done) dcount++;
         end
         chk("midrst_no_done", dcount, 0);
         last_exp = '0;
         run_op(16'hABCD, 16'h0012, {1'b0, 16'h098B, 16'h0007}, 0);
      end

      // Random regression with biased corner operands.
      for (int i = 0; i < 2500; i++) begin
         logic [15:0] a;
         logic [15:0] b;
         int sel;
         sel = $urandom_range(0, 7);
         a = (sel == 0) ? 16'd0 : (sel == 1) ? 16'hFFFF : 16'($urandom);
         sel = $urandom_range(0, 7);
         b = (sel == 0) ? 16'd0 : (sel == 1) ? 16'hFFFF :
             (sel == 2) ? 16'($urandom_range(1, 15)) : 16'($urandom);
         run_op(a, b, model(a, b), 0);
      end

      @(negedge clk);
      chk("done_count", done_cnt, accepted);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
